// File: rtl/inst_buffer_pkg.sv
// inst_buffer_pkg
//   Shared types and defaults for the instruction buffer between fetch and
//   the decoder lanes.
//   - inst_t / addr_t : 32-bit instruction word and address.
//   - NOP            : addi x0,x0,0, shown on decoder lanes with no instruction.
//   - ib_entry_t     : one buffered {inst, pc} pair.
//   - IB_* defaults  : default geometry of the buffer.
package inst_buffer_pkg;

  typedef logic [31:0] inst_t;
  typedef logic [31:0] addr_t;

  localparam inst_t NOP = 32'h0000_0013;

  typedef struct packed {
    inst_t inst;
    addr_t pc;
  } ib_entry_t;

  localparam int IB_DEPTH          = 8;
  localparam int IB_FETCH_WIDTH    = 2;
  localparam int IB_DISPATCH_WIDTH = 2;

endpackage

// File: rtl/inst_buffer.sv
// inst_buffer
//   In-order circular instruction queue. Fetch enqueues up to FETCH_WIDTH
//   instructions per cycle; the oldest DISPATCH_WIDTH entries are presented
//   to the decoder lanes and dispatch_count of them retire each cycle.
// Ports
//   clock          : system clock, rising edge
//   reset          : synchronous active-high reset (priority over flush)
//   flush          : squash all contents; drops this cycle's fetch group
//   fetch_valid    : contiguous-from-lane-0 valid mask of the fetch group
//   fetch_inst/pc  : fetch group, lane 0 oldest
//   fetch_ready    : room for a full fetch group (registered count only)
//   dec_valid      : decoder lane i holds a real instruction
//   dec_inst/pc    : decoder lane contents, NOP / 0 when not valid
//   dispatch_count : lanes consumed this cycle, starting at lane 0
//   count          : current occupancy
module inst_buffer
  import inst_buffer_pkg::*;
#(
  parameter int DEPTH          = IB_DEPTH,
  parameter int FETCH_WIDTH    = IB_FETCH_WIDTH,
  parameter int DISPATCH_WIDTH = IB_DISPATCH_WIDTH,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int DC_W  = $clog2(DISPATCH_WIDTH + 1)
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              flush,
  input  logic [FETCH_WIDTH-1:0]            fetch_valid,
  input  inst_t [FETCH_WIDTH-1:0]           fetch_inst,
  input  addr_t [FETCH_WIDTH-1:0]           fetch_pc,
  output logic                              fetch_ready,
  output logic [DISPATCH_WIDTH-1:0]         dec_valid,
  output inst_t [DISPATCH_WIDTH-1:0]        dec_inst,
  output addr_t [DISPATCH_WIDTH-1:0]        dec_pc,
  input  logic [DC_W-1:0]                   dispatch_count,
  output logic [CNT_W-1:0]                  count
);

  ib_entry_t        entries [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic             enq_en;
  logic [CNT_W-1:0] enq_n;
  logic [CNT_W-1:0] deq_n;
  logic [CNT_W-1:0] dc_ext;

  // The mask is contiguous from lane 0, so its population count is also the
  // number of leading valid lanes.
  function automatic logic [CNT_W-1:0] popcount(input logic [FETCH_WIDTH-1:0] mask);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int k = 0; k < FETCH_WIDTH; k++) begin
      n = n + CNT_W'(mask[k]);
    end
    return n;
  endfunction

  assign fetch_ready = (CNT_W'(DEPTH) - count) >= CNT_W'(FETCH_WIDTH);
  assign enq_en      = fetch_ready && !flush && !reset;
  assign enq_n       = enq_en ? popcount(fetch_valid) : '0;
  assign dc_ext      = CNT_W'(dispatch_count);
  // Over-dispatch is illegal; clamp so the pointers never pass each other.
  assign deq_n       = (dc_ext > count) ? count : dc_ext;

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PTR_W'(deq_n);
      tail  <= tail + PTR_W'(enq_n);
      count <= count + enq_n - deq_n;
    end
  end

  // Storage carries no reset; stale entries are never shown because the
  // output lanes are gated by count.
  always_ff @(posedge clock) begin
    if (enq_en) begin
      for (int k = 0; k < FETCH_WIDTH; k++) begin
        if (fetch_valid[k]) begin
          entries[tail + PTR_W'(k)] <= '{inst: fetch_inst[k], pc: fetch_pc[k]};
        end
      end
    end
  end

  always_comb begin
    dec_valid = '0;
    dec_inst  = '0;
    dec_pc    = '0;
    for (int i = 0; i < DISPATCH_WIDTH; i++) begin
      dec_valid[i] = count > CNT_W'(i);
      if (dec_valid[i]) begin
        dec_inst[i] = entries[head + PTR_W'(i)].inst;
        dec_pc[i]   = entries[head + PTR_W'(i)].pc;
      end else begin
        dec_inst[i] = NOP;
        dec_pc[i]   = '0;
      end
    end
  end

  a_no_over_dispatch : assert property (
    @(posedge clock) disable iff (reset) (dc_ext <= count)
  ) else $error("inst_buffer: dispatch_count %0d exceeds count %0d", dispatch_count, count);

endmodule

// File: tb/tb_inst_buffer.sv
module tb_inst_buffer;

  localparam int DEPTH = 8;
  localparam int FW    = 2;
  localparam int DW    = 2;
  localparam logic [31:0] NOPW = 32'h0000_0013;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              flush = 1'b0;
  logic [FW-1:0]     fetch_valid = '0;
  logic [FW-1:0][31:0] fetch_inst = '0;
  logic [FW-1:0][31:0] fetch_pc   = '0;
  logic              fetch_ready;
  logic [DW-1:0]     dec_valid;
  logic [DW-1:0][31:0] dec_inst;
  logic [DW-1:0][31:0] dec_pc;
  logic [1:0]        dispatch_count = '0;
  logic [3:0]        count;

  inst_buffer dut (
    .clock          (clock),
    .reset          (reset),
    .flush          (flush),
    .fetch_valid    (fetch_valid),
    .fetch_inst     (fetch_inst),
    .fetch_pc       (fetch_pc),
    .fetch_ready    (fetch_ready),
    .dec_valid      (dec_valid),
    .dec_inst       (dec_inst),
    .dec_pc         (dec_pc),
    .dispatch_count (dispatch_count),
    .count          (count)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: a plain FIFO of {inst, pc} pairs.
  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
  } ent_t;
  ent_t q[$];
  bit   model_on = 0;

  always @(posedge clock) begin
    if (reset || flush) begin
      q.delete();
      if (reset) model_on = 1;
    end else begin
      int room_ok;
      int deq;
      room_ok = (DEPTH - q.size()) >= FW;
      deq = (int'(dispatch_count) > q.size()) ? q.size() : int'(dispatch_count);
      for (int d = 0; d < deq; d++) void'(q.pop_front());
      if (room_ok) begin
        for (int k = 0; k < FW; k++)
          if (fetch_valid[k]) q.push_back('{inst: fetch_inst[k], pc: fetch_pc[k]});
      end
    end
  end

  always @(negedge clock) begin
    if (model_on) begin
      chk("count", 32'(count), 32'(q.size()));
      chk("fetch_ready", 32'(fetch_ready), 32'((DEPTH - q.size()) >= FW));
      for (int i = 0; i < DW; i++) begin
        chk($sformatf("dec_valid[%0d]", i), 32'(dec_valid[i]), 32'(i < q.size()));
        chk($sformatf("dec_inst[%0d]", i), dec_inst[i], (i < q.size()) ? q[i].inst : NOPW);
        chk($sformatf("dec_pc[%0d]", i), dec_pc[i], (i < q.size()) ? q[i].pc : 32'h0);
      end
    end
  end

  int seq = 0;

  task automatic step(input logic [1:0] fv, input logic [1:0] dc,
                      input logic fl = 1'b0, input logic rs = 1'b0);
    fetch_valid    = fv;
    dispatch_count = dc;
    flush          = fl;
    reset          = rs;
    for (int k = 0; k < FW; k++) begin
      fetch_inst[k] = 32'hC000_0000 + 32'(seq + k);
      fetch_pc[k]   = 32'h1000 + 32'((seq + k) * 4);
    end
    seq += FW;
    @(posedge clock);
    #1;
  endtask

  task automatic step_ab(input logic [31:0] a, input logic [31:0] pa,
                         input logic [31:0] b, input logic [31:0] pb);
    fetch_valid    = 2'b11;
    dispatch_count = 2'd0;
    flush          = 1'b0;
    reset          = 1'b0;
    fetch_inst[0] = a; fetch_pc[0] = pa;
    fetch_inst[1] = b; fetch_pc[1] = pb;
    @(posedge clock);
    #1;
  endtask

  initial begin
    step(2'b00, 2'd0, 1'b0, 1'b1);
    step(2'b00, 2'd0, 1'b0, 1'b1);
    chk("rst count", 32'(count), 32'd0);
    chk("rst dec_valid", 32'(dec_valid), 32'd0);
    chk("rst fetch_ready", 32'(fetch_ready), 32'd1);
    chk("rst dec_inst0", dec_inst[0], 32'h0000_0013);
    chk("rst dec_inst1", dec_inst[1], 32'h0000_0013);

    step_ab(32'hAAAA_0001, 32'h0, 32'hBBBB_0002, 32'h4);
    chk("first count", 32'(count), 32'd2);
    chk("first dec_valid", 32'(dec_valid), 32'h3);
    chk("first inst0", dec_inst[0], 32'hAAAA_0001);
    chk("first inst1", dec_inst[1], 32'hBBBB_0002);
    chk("first pc1", dec_pc[1], 32'h4);

    // Fill to full, then a blocked fetch group must be ignored.
    for (int n = 0; n < 3; n++) step(2'b11, 2'd0);
    chk("full count", 32'(count), 32'd8);
    chk("full ready", 32'(fetch_ready), 32'd0);
    step(2'b11, 2'd0);
    chk("blocked count", 32'(count), 32'd8);
    chk("blocked inst0", dec_inst[0], 32'hAAAA_0001);
    step(2'b00, 2'd2);
    chk("drain count", 32'(count), 32'd6);
    chk("drain ready", 32'(fetch_ready), 32'd1);

    // Steady state at 4 entries, wraps both pointers.
    step(2'b00, 2'd2);
    for (int n = 0; n < 10; n++) step(2'b11, 2'd2);
    chk("steady count", 32'(count), 32'd4);

    // Single entry.
    step(2'b00, 2'd2);
    step(2'b00, 2'd1);
    chk("single valid", 32'(dec_valid), 32'h1);
    chk("single lane1 nop", dec_inst[1], 32'h0000_0013);
    seq = 100;
    step(2'b01, 2'd1);
    chk("single count", 32'(count), 32'd1);
    chk("single new inst", dec_inst[0], 32'hC000_0064);

    // Flush with a fetch group in the same cycle.
    step(2'b11, 2'd0);
    step(2'b11, 2'd0);
    chk("pre-flush count", 32'(count), 32'd5);
    step(2'b11, 2'd0, 1'b1);
    chk("flush count", 32'(count), 32'd0);
    chk("flush valid", 32'(dec_valid), 32'd0);
    chk("flush ready", 32'(fetch_ready), 32'd1);

    // Reset mid-operation while dispatching.
    for (int n = 0; n < 3; n++) step(2'b11, 2'd0);
    chk("pre-reset count", 32'(count), 32'd6);
    step(2'b11, 2'd2, 1'b0, 1'b1);
    chk("mid-reset count", 32'(count), 32'd0);
    chk("mid-reset inst0", dec_inst[0], 32'h0000_0013);
    seq = 200;
    step(2'b01, 2'd0);
    chk("post-reset inst0", dec_inst[0], 32'hC000_00C8);
    chk("post-reset pc0", dec_pc[0], 32'h1000 + 32'd800);
    step(2'b00, 2'd1);
    step(2'b00, 2'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_buffer.md
Name: inst_buffer

Overview:
- In-order circular instruction queue between fetch and the per-lane instruction decoders.
- Accepts up to FETCH_WIDTH fetched instructions per cycle.
- Presents the oldest up to DISPATCH_WIDTH instructions, with valid bits, to the decoder lanes, and retires as many as dispatch reports consumed.
- Flushed on branch mispredict or any pipeline squash.

Parameters:
- DEPTH, 8, number of entries; must be a power of two and at least FETCH_WIDTH.
- FETCH_WIDTH, 2, maximum instructions enqueued per cycle.
- DISPATCH_WIDTH, 2, number of decoder lanes fed per cycle; at most DEPTH.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  squash all contents this cycle.
- fetch_valid  in  FETCH_WIDTH  per-lane valid; must be contiguous from lane 0 (e.g. 2'b01, 2'b11, never 2'b10).
- fetch_inst  in  FETCH_WIDTH x 32 (INST)  fetched instruction words; lane 0 is oldest.
- fetch_pc  in  FETCH_WIDTH x 32 (ADDR)  PC of each fetched instruction.
- fetch_ready  out  1  buffer can accept a full FETCH_WIDTH group this cycle.
- dec_valid  out  DISPATCH_WIDTH  lane i holds a real instruction; drives the decoder valid input.
- dec_inst  out  DISPATCH_WIDTH x 32 (INST)  instruction for decoder lane i; lane 0 is oldest.
- dec_pc  out  DISPATCH_WIDTH x 32 (ADDR)  PC for lane i.
- dispatch_count  in  $clog2(DISPATCH_WIDTH+1)  number of lanes, starting at lane 0, consumed this cycle.
- count  out  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- State:
  - head and tail pointers, each $clog2(DEPTH) bits, wrapping modulo DEPTH.
  - count register.
  - entry array of {inst, pc}.
- Reset:
  - head=0, tail=0, count=0.
  - Outputs: dec_valid=0, fetch_ready=1, count=0, and every dec_inst lane shows `NOP.
  - Entry contents are don't-care.
- fetch_ready:
  - Combinational: (DEPTH - count) >= FETCH_WIDTH.
  - Uses registered count only; no credit for a same-cycle dequeue.
- Enqueue:
  - When fetch_ready and not flush, each valid lane k is written to entry (tail+k) mod DEPTH.
  - tail advances by popcount(fetch_valid).
  - If fetch_ready=0, fetch_valid is ignored and fetch must hold the group.
- Dequeue:
  - dec_valid[i] = (count > i).
  - dec_inst[i] / dec_pc[i] = entry (head+i) mod DEPTH when valid; otherwise `NOP (32'h0000_0013, addi x0,x0,0) and PC 0.
  - Outputs are combinational from registered state, so a write becomes visible the cycle after it is enqueued (1-cycle minimum latency).
  - head advances by dispatch_count.
  - dispatch_count > count is illegal: assertion fires in simulation; RTL clamps the dequeue to count.
- Simultaneous enqueue and dequeue in one cycle: count_next = count + enq_n - deq_n.
  - Always legal, because fetch_ready already guarantees room before any dequeue.
- Wrap-around: pointer arithmetic is modulo DEPTH. A group that straddles index DEPTH-1 to 0 is written and read in the correct order.
- Full (count=DEPTH): dec_valid is all ones and fetch_ready=0.
- Empty (count=0): dec_valid is all zeros, every lane shows `NOP, and any dispatch_count>0 is ignored.
- flush:
  - Next cycle: head=tail=0, count=0.
  - Overrides enqueue and dequeue in the same cycle; the fetch group presented that cycle is dropped.
  - reset has priority over flush.
- Reset asserted mid-operation: all contents are discarded exactly as with flush.
  - Outputs show the reset values starting the cycle after reset is sampled.
- No combinational path from the fetch inputs to the dec_* outputs.
- fetch_ready depends only on count.

Decomposition:
- sys_defs.svh:
  - INST and ADDR types (existing).
  - `NOP constant 32'h0000_0013.
  - IB_ENTRY struct {INST inst; ADDR pc;}.
  - Default values for IB_DEPTH, FETCH_WIDTH and DISPATCH_WIDTH.
- No sub-module. The popcount of the contiguous fetch_valid mask is an inline function. The entry array, pointers and count all live in one module.

Test Plan:
- Reset, then fetch_valid=2'b11 with insts A,B and PCs 0x0,0x4, dispatch_count=0 → next cycle count=2, dec_valid=2'b11, dec_inst={A,B}, dec_pc={0x0,0x4}.
- Fill to 8 entries → fetch_ready=0. Drive fetch_valid=2'b11 → count stays 8 and contents are unchanged. Then dispatch_count=2 → count=6 and fetch_ready=1.
- Steady state with count=4, enqueue 2 and dispatch 2 every cycle for 10 cycles → count stays 4, head/tail wrap past index 7 with no gaps, and output order equals input order.
- Single entry: count=1 → dec_valid=2'b01 and dec_inst[1]=32'h0000_0013. dispatch_count=1 together with fetch_valid=2'b01 → count=1 and the new instruction appears on lane 0.
- count=5 with flush=1 and fetch_valid=2'b11 in the same cycle → next cycle count=0, dec_valid=0, fetch_ready=1, and the fetched pair is absent.
- reset asserted while count=6 and a dispatch is active → next cycle count=0 and all outputs show reset values. A subsequent enqueue lands at entry 0.
